// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: parametrised multi-cycle ALU.
// ADD/SUB/SHIFT/ROT finish at the accepting edge; MUL (shift-add) and DIV
// (restoring) iterate for WIDTH cycles behind a start/busy/valid handshake.
// Optional feature macro: ALU_MC_DIV_EN (divider built only when defined).
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             valid,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [2:0]    OP_ADD   = 3'd0;
  localparam logic [2:0]    OP_SUB   = 3'd1;
  localparam logic [2:0]    OP_MUL   = 3'd2;
  localparam logic [2:0]    OP_SHIFT = 3'd4;
  localparam logic [2:0]    OP_ROT   = 3'd5;

`ifdef ALU_MC_DIV_EN
  localparam logic [2:0]    OP_DIV   = 3'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_MUL} state_t;
`endif

  state_t           r_state;
  state_t           w_stateNext;
  logic [CW-1:0]    r_count;
  // r_opnd holds the multiplicand (MUL) or divisor (DIV); r_hi/r_lo are the
  // running product halves (MUL) or remainder/quotient pair (DIV).
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_resultHi;
  logic             r_valid;
  logic             r_zero;
  logic             r_carry;
  logic             r_err;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_carry;
  logic             w_err;
  logic             w_goMul;
  logic             w_last;
  logic [WIDTH:0]   w_mulAdd;
  logic [WIDTH-1:0] w_mulHi;
  logic [WIDTH-1:0] w_mulLo;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_last   = (r_count == LAST);
  assign w_mulAdd = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
  assign w_mulHi  = w_mulAdd[WIDTH:1];
  assign w_mulLo  = {w_mulAdd[0], r_lo[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  logic             w_goDiv;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divSub;
  logic             w_divGe;
  logic [WIDTH-1:0] w_divRem;
  logic [WIDTH-1:0] w_divQuo;

  assign w_divShift = {r_hi, r_lo[WIDTH-1]};
  assign w_divSub   = w_divShift - {1'b0, r_opnd};
  assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
  assign w_divRem   = w_divGe ? w_divSub[WIDTH-1:0] : w_divShift[WIDTH-1:0];
  assign w_divQuo   = {r_lo[WIDTH-2:0], w_divGe};
`endif

  // Decode the requested op into a single-cycle result or an iterative launch.
  always_comb begin
    w_res   = '0;
    w_hi    = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    w_goMul = 1'b0;
`ifdef ALU_MC_DIV_EN
    w_goDiv = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = a - b;
        w_carry = (a < b);
      end
      OP_MUL: w_goMul = 1'b1;
`ifdef ALU_MC_DIV_EN
      OP_DIV: begin
        if (b == '0) begin
          w_res = '1;
          w_hi  = a;
          w_err = 1'b1;
        end else begin
          w_goDiv = 1'b1;
        end
      end
`endif
      OP_SHIFT: begin
        if (dir) begin
          w_res   = a >> 1;
          w_carry = a[0];
        end else begin
          w_res   = a << 1;
          w_carry = a[WIDTH-1];
        end
      end
      OP_ROT: begin
        if (dir) w_res = {a[0], a[WIDTH-1:1]};
        else     w_res = {a[WIDTH-2:0], a[WIDTH-1]};
      end
      default: w_err = 1'b1;
    endcase
  end

  // Next-state logic: leave IDLE only for iterative ops, return after WIDTH steps.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && w_goMul) w_stateNext = ST_MUL;
`ifdef ALU_MC_DIV_EN
        else if (start && w_goDiv) w_stateNext = ST_DIV;
`endif
      end
      ST_MUL: if (w_last) w_stateNext = ST_IDLE;
`ifdef ALU_MC_DIV_EN
      ST_DIV: if (w_last) w_stateNext = ST_IDLE;
`endif
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  // Operand capture, iteration steps and registered outputs with one-cycle valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_resultHi <= '0;
      r_valid    <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_hi    <= '0;
            if (w_goMul) begin
              r_opnd <= a;
              r_lo   <= b;
            end
`ifdef ALU_MC_DIV_EN
            else if (w_goDiv) begin
              r_opnd <= b;
              r_lo   <= a;
            end
`endif
            else begin
              r_result   <= w_res;
              r_resultHi <= w_hi;
              r_zero     <= (w_res == '0);
              r_carry    <= w_carry;
              r_err      <= w_err;
              r_valid    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          r_hi    <= w_mulHi;
          r_lo    <= w_mulLo;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_count    <= '0;
            r_result   <= w_mulLo;
            r_resultHi <= w_mulHi;
            r_zero     <= (w_mulLo == '0);
            r_carry    <= (w_mulHi != '0);
            r_err      <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
`ifdef ALU_MC_DIV_EN
        ST_DIV: begin
          r_hi    <= w_divRem;
          r_lo    <= w_divQuo;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_count    <= '0;
            r_result   <= w_divQuo;
            r_resultHi <= w_divRem;
            r_zero     <= (w_divQuo == '0);
            r_carry    <= 1'b0;
            r_err      <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
`endif
        default: r_count <= '0;
      endcase
    end
  end

  assign result    = r_result;
  assign result_hi = r_resultHi;
  assign valid     = r_valid;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// tb_alu_mc: directed vector table, reset/ignore-start sequences and a
// randomized phase checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic         dir   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         valid;
  logic         busy;
  logic         zero;
  logic         carry;
  logic         err;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prevRes   = '0;
  logic [W-1:0] prevHi    = '0;
  logic         prevZero  = 1'b0;
  logic         prevCarry = 1'b0;
  logic         prevErr   = 1'b0;

  typedef struct {
    logic [2:0]   op;
    logic         dir;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         e;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .dir(dir),
    .a(a), .b(b), .result(result), .result_hi(result_hi), .valid(valid),
    .busy(busy), .zero(zero), .carry(carry), .err(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic d, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic c, output logic e,
                       output int lat);
    int ia, ib, v;
    ia = int'(x); ib = int'(y);
    r = '0; h = '0; c = 1'b0; e = 1'b0; lat = 1;
    case (o)
      3'd0: begin v = ia + ib; r = 8'(v % 256); c = (v > 255); end
      3'd1: begin r = 8'((ia - ib + 256) % 256); c = (ia < ib); end
      3'd2: begin v = ia * ib; r = 8'(v % 256); h = 8'(v / 256); c = ((v / 256) != 0); lat = W; end
`ifdef ALU_MC_DIV_EN
      3'd3: begin
        if (ib == 0) begin r = 8'hFF; h = x; e = 1'b1; end
        else begin r = 8'(ia / ib); h = 8'(ia % ib); lat = W; end
      end
`endif
      3'd4: begin
        if (d) begin r = 8'(ia / 2); c = ((ia % 2) == 1); end
        else   begin r = 8'((ia * 2) % 256); c = (ia >= 128); end
      end
      3'd5: begin
        if (d) r = 8'(ia / 2 + (ia % 2) * 128);
        else   r = 8'((ia * 2) % 256 + ia / 128);
      end
      default: e = 1'b1;
    endcase
  endtask

  // Launch one op, scramble inputs after capture, check busy/hold, then completion.
  task automatic applyStimulus(input logic [2:0] o, input logic d, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] er, input logic [W-1:0] eh, input logic ec, input logic ee,
                               input int lat, input string tag);
    start = 1'b1; op = o; dir = d; a = x; b = y;
    @(posedge clock); #1;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom); dir = 1'($urandom);
    start = (lat > 1) ? 1'($urandom) : 1'b0;
    if (lat > 1) begin
      for (int i = 0; i < lat; i++) begin
        checkOutput({tag, " busy"}, busy, 1);
        checkOutput({tag, " valid low while busy"}, valid, 0);
        checkOutput({tag, " result held"}, result, prevRes);
        checkOutput({tag, " result_hi held"}, result_hi, prevHi);
        checkOutput({tag, " flags held"}, {zero, carry, err}, {prevZero, prevCarry, prevErr});
        @(posedge clock); #1;
        if (i < lat - 1) begin
          start = 1'($urandom); op = 3'($urandom);
          a = W'($urandom); b = W'($urandom);
        end
      end
    end
    start = 1'b0;
    checkOutput({tag, " valid"}, valid, 1);
    checkOutput({tag, " busy done"}, busy, 0);
    checkOutput({tag, " result"}, result, er);
    checkOutput({tag, " result_hi"}, result_hi, eh);
    checkOutput({tag, " zero"}, zero, (er == '0));
    checkOutput({tag, " carry"}, carry, ec);
    checkOutput({tag, " err"}, err, ee);
    prevRes = er; prevHi = eh; prevZero = (er == '0); prevCarry = ec; prevErr = ee;
  endtask

  initial begin
    logic [W-1:0] rr, rh, ra, rb;
    logic         rc, re, rd, sawValid;
    logic [2:0]   ro;
    int           rl;

    vecs.push_back('{3'd0, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1, "add_ff_01"});
    vecs.push_back('{3'd1, 1'b0, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b1, 1'b0, 1, "sub_10_20"});
    vecs.push_back('{3'd2, 1'b0, 8'hC8, 8'h03, 8'h58, 8'h02, 1'b1, 1'b0, W, "mul_c8_03"});
    vecs.push_back('{3'd4, 1'b0, 8'h81, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0, 1, "shl_81"});
    vecs.push_back('{3'd5, 1'b1, 8'h01, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0, 1, "ror_01"});
    vecs.push_back('{3'd7, 1'b0, 8'h55, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, 1, "op7"});
    vecs.push_back('{3'd6, 1'b1, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b1, 1, "op6"});
    vecs.push_back('{3'd4, 1'b1, 8'h03, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1, "shr_03"});
    vecs.push_back('{3'd5, 1'b0, 8'h80, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1, "rol_80"});
    vecs.push_back('{3'd2, 1'b0, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, W, "mul_00_05"});
    vecs.push_back('{3'd2, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, W, "mul_ff_ff"});
    vecs.push_back('{3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1, "add_7f_01"});
    vecs.push_back('{3'd1, 1'b0, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1, "sub_05_05"});
`ifdef ALU_MC_DIV_EN
    vecs.push_back('{3'd3, 1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, W, "div_200_7"});
    vecs.push_back('{3'd3, 1'b0, 8'h09, 8'h00, 8'hFF, 8'h09, 1'b0, 1'b1, 1, "div_by_zero"});
    vecs.push_back('{3'd3, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, W, "div_ff_ff"});
    vecs.push_back('{3'd3, 1'b0, 8'h03, 8'h0A, 8'h00, 8'h03, 1'b0, 1'b0, W, "div_3_10"});
`else
    vecs.push_back('{3'd3, 1'b0, 8'h0A, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 1, "div_disabled"});
`endif

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset result", result, 0);
    checkOutput("reset result_hi", result_hi, 0);
    checkOutput("reset valid", valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset flags", {zero, carry, err}, 3'b000);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed table.
    foreach (vecs[i])
      applyStimulus(vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi,
                    vecs[i].c, vecs[i].e, vecs[i].lat, vecs[i].name);

    // Asynchronous reset in the middle of a multiply discards it.
    start = 1'b1; op = 3'd2; dir = 1'b0; a = 8'd3; b = 8'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("midmul busy before reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midmul reset result", result, 0);
    checkOutput("midmul reset result_hi", result_hi, 0);
    checkOutput("midmul reset busy", busy, 0);
    checkOutput("midmul reset valid", valid, 0);
    checkOutput("midmul reset flags", {zero, carry, err}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b0;
    prevRes = '0; prevHi = '0; prevZero = 1'b0; prevCarry = 1'b0; prevErr = 1'b0;
    sawValid = 1'b0;
    repeat (W + 3) begin
      @(posedge clock); #1;
      if (valid || busy) sawValid = 1'b1;
    end
    checkOutput("no completion after reset", sawValid, 0);
    applyStimulus(3'd0, 1'b0, 8'd1, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0, 1, "add_after_reset");

    // Randomized ops against the model, issued back-to-back.
    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      rd = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(ro, rd, ra, rb, rr, rh, rc, re, rl);
      applyStimulus(ro, rd, ra, rb, rr, rh, rc, re, rl, $sformatf("rand%0d_op%0d", n, ro));
    end

    @(posedge clock); #1;
    checkOutput("valid drops when idle", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
